// File: rtl/bloco_controle.sv
// Control FSM for the polynomial datapath: sequences R2 = A*x^2 + B*x + C.
// Latency: start sampled at edge k -> pronto high after edge k+6 (seven states).
// Backpressure: none; start is only sampled in IDLE (or in DONE when HOLD_PRONTO=1).
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   start           request a new evaluation
//   LX, LH, LS      BO load enables for R0, R1, R2
//   H               ALU op (1 = multiply, 0 = add)
//   M0, M1, M2      BO mux selects (constant, ALU op1, ALU op2)
//   ocupado         evaluation in progress (LOADX..SUMC)
//   pronto          result valid in BO R2
module bloco_controle #(
  parameter int STATE_W     = 3,
  parameter bit HOLD_PRONTO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       LX,
  output logic       LH,
  output logic       LS,
  output logic       H,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic       ocupado,
  output logic       pronto
);

  typedef enum logic [STATE_W-1:0] {
    IDLE  = STATE_W'(0),
    LOADX = STATE_W'(1),
    X2    = STATE_W'(2),
    AX2   = STATE_W'(3),
    BX    = STATE_W'(4),
    SUM1  = STATE_W'(5),
    SUMC  = STATE_W'(6),
    DONE  = STATE_W'(7)
  } state_t;

  typedef struct packed {
    logic       lx;
    logic       lh;
    logic       ls;
    logic       h;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       ocupado;
    logic       pronto;
  } ctl_t;

  state_t state_q, state_d;
  ctl_t   ctl_q, ctl_d;

  // Next-state logic.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = start ? LOADX : IDLE;
      LOADX:   state_d = X2;
      X2:      state_d = AX2;
      AX2:     state_d = BX;
      BX:      state_d = SUM1;
      SUM1:    state_d = SUMC;
      SUMC:    state_d = DONE;
      DONE: begin
        if (HOLD_PRONTO) state_d = start ? LOADX : DONE;
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it, so
  // the output flops always reflect state_q and nothing combinational leaves
  // the block.
  always_comb begin
    ctl_d = '0;
    case (state_d)
      LOADX: begin
        ctl_d.lx      = 1'b1;
        ctl_d.ocupado = 1'b1;
      end
      X2: begin // R1 <= x * x
        ctl_d.m1      = 2'd1;
        ctl_d.m2      = 2'd0;
        ctl_d.h       = 1'b1;
        ctl_d.lh      = 1'b1;
        ctl_d.ocupado = 1'b1;
      end
      AX2: begin // R2 <= A * x^2
        ctl_d.m0      = 2'd1;
        ctl_d.m1      = 2'd0;
        ctl_d.m2      = 2'd2;
        ctl_d.h       = 1'b1;
        ctl_d.ls      = 1'b1;
        ctl_d.ocupado = 1'b1;
      end
      BX: begin // R1 <= B * x
        ctl_d.m0      = 2'd2;
        ctl_d.m1      = 2'd0;
        ctl_d.m2      = 2'd0;
        ctl_d.h       = 1'b1;
        ctl_d.lh      = 1'b1;
        ctl_d.ocupado = 1'b1;
      end
      SUM1: begin // R2 <= R1 + R2
        ctl_d.m1      = 2'd2;
        ctl_d.m2      = 2'd3;
        ctl_d.ls      = 1'b1;
        ctl_d.ocupado = 1'b1;
      end
      SUMC: begin // R2 <= C + R2
        ctl_d.m0      = 2'd3;
        ctl_d.m1      = 2'd0;
        ctl_d.m2      = 2'd3;
        ctl_d.ls      = 1'b1;
        ctl_d.ocupado = 1'b1;
      end
      DONE: begin
        ctl_d.pronto  = 1'b1;
      end
      default: ctl_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  assign LX      = ctl_q.lx;
  assign LH      = ctl_q.lh;
  assign LS      = ctl_q.ls;
  assign H       = ctl_q.h;
  assign M0      = ctl_q.m0;
  assign M1      = ctl_q.m1;
  assign M2      = ctl_q.m2;
  assign ocupado = ctl_q.ocupado;
  assign pronto  = ctl_q.pronto;

endmodule

// File: tb/tb_bloco_controle.sv
module tb_bloco_controle;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start_h = 1'b0;

  logic       lx, lh, ls, h, ocupado, pronto;
  logic [1:0] m0, m1, m2;
  logic       lx_h, lh_h, ls_h, h_h, ocupado_h, pronto_h;
  logic [1:0] m0_h, m1_h, m2_h;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bloco_controle #(.STATE_W(3), .HOLD_PRONTO(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .LX(lx), .LH(lh), .LS(ls), .H(h),
    .M0(m0), .M1(m1), .M2(m2),
    .ocupado(ocupado), .pronto(pronto)
  );

  bloco_controle #(.STATE_W(3), .HOLD_PRONTO(1'b1)) dut_h (
    .clk(clk), .rst(rst), .start(start_h),
    .LX(lx_h), .LH(lh_h), .LS(ls_h), .H(h_h),
    .M0(m0_h), .M1(m1_h), .M2(m2_h),
    .ocupado(ocupado_h), .pronto(pronto_h)
  );

  // Observed control word: {LX,LH,LS,H,M0,M1,M2,ocupado,pronto}
  wire [11:0] ctl   = {lx, lh, ls, h, m0, m1, m2, ocupado, pronto};
  wire [11:0] ctl_h = {lx_h, lh_h, ls_h, h_h, m0_h, m1_h, m2_h, ocupado_h, pronto_h};

  // Hand-written expected control words per state.
  localparam logic [11:0] E_IDLE  = 12'b0000_0000_0000;
  localparam logic [11:0] E_LOADX = 12'b1000_0000_0010;
  localparam logic [11:0] E_X2    = 12'b0101_0001_0010;
  localparam logic [11:0] E_AX2   = 12'b0011_0100_1010;
  localparam logic [11:0] E_BX    = 12'b0101_1000_0010;
  localparam logic [11:0] E_SUM1  = 12'b0010_0010_1110;
  localparam logic [11:0] E_SUMC  = 12'b0010_1100_1110;
  localparam logic [11:0] E_DONE  = 12'b0000_0000_0001;

  logic [11:0] seq [7];
  initial begin
    seq[0] = E_LOADX; seq[1] = E_X2;   seq[2] = E_AX2; seq[3] = E_BX;
    seq[4] = E_SUM1;  seq[5] = E_SUMC; seq[6] = E_DONE;
  end

  // Behavioural BO datapath driven by the controller under test.
  logic [15:0] a_in, b_in, c_in, x_in;
  logic [15:0] r0, r1, r2;
  initial begin
    r0 = '0; r1 = '0; r2 = '0;
    a_in = '0; b_in = '0; c_in = '0; x_in = '0;
  end

  always @(posedge clk) begin
    logic [15:0] kv, op1, op2, alu;
    case (m0)
      2'd0: kv = 16'd0;
      2'd1: kv = a_in;
      2'd2: kv = b_in;
      default: kv = c_in;
    endcase
    case (m1)
      2'd0: op1 = kv;
      2'd1: op1 = r0;
      2'd2: op1 = r1;
      default: op1 = r2;
    endcase
    case (m2)
      2'd0: op2 = r0;
      2'd1: op2 = kv;
      2'd2: op2 = r1;
      default: op2 = r2;
    endcase
    alu = h ? 16'(op1 * op2) : 16'(op1 + op2);
    if (lx) r0 <= x_in;
    if (lh) r1 <= alu;
    if (ls) r2 <= alu;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_h = 1'b0;
    tick(); tick();
    checks++;
    if (ctl !== E_IDLE) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", ctl, E_IDLE);
    end
    checks++;
    if (ctl_h !== E_IDLE) begin
      errors++; $display("FAIL reset_outputs_hold: got %b expected %b", ctl_h, E_IDLE);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ctl !== E_IDLE) begin
        errors++; $display("FAIL idle_no_start[%0d]: got %b expected %b", i, ctl, E_IDLE);
      end
    end
  endtask

  // One evaluation from IDLE: full control sequence, pronto timing, R2 value.
  task automatic test_eval(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] x,
                           input logic [15:0] exp_r2);
    a_in = a; b_in = b; c_in = c; x_in = x;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (ctl !== seq[i]) begin
        errors++; $display("FAIL eval_seq[%0d]: got %b expected %b", i, ctl, seq[i]);
      end
      if (i < 6) tick();
    end
    checks++;
    if (r2 !== exp_r2) begin
      errors++; $display("FAIL eval_r2: got %0d expected %0d", r2, exp_r2);
    end
    tick();
    checks++;
    if (ctl !== E_IDLE) begin
      errors++; $display("FAIL eval_pronto_pulse: got %b expected %b", ctl, E_IDLE);
    end
  endtask

  task automatic test_ignore_start();
    int n_pronto;
    a_in = 16'd3; b_in = 16'd2; c_in = 16'd5; x_in = 16'd2;
    n_pronto = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (ctl !== E_X2) begin
      errors++; $display("FAIL ignore_in_x2: got %b expected %b", ctl, E_X2);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 2; i < 7; i++) begin
      checks++;
      if (ctl !== seq[i]) begin
        errors++; $display("FAIL ignore_seq[%0d]: got %b expected %b", i, ctl, seq[i]);
      end
      if (pronto) n_pronto++;
      if (i < 6) tick();
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pronto) n_pronto++;
      checks++;
      if (r2 !== 16'd21) begin
        errors++; $display("FAIL ignore_r2_stable[%0d]: got %0d expected 21", i, r2);
      end
    end
    checks++;
    if (n_pronto !== 1) begin
      errors++; $display("FAIL ignore_pronto_count: got %0d expected 1", n_pronto);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (ctl !== E_BX) begin
      errors++; $display("FAIL rst_mid_in_bx: got %b expected %b", ctl, E_BX);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ctl !== E_IDLE) begin
      errors++; $display("FAIL rst_mid_idle: got %b expected %b", ctl, E_IDLE);
    end
    tick();
    checks++;
    if (ctl !== E_IDLE) begin
      errors++; $display("FAIL rst_mid_stays_idle: got %b expected %b", ctl, E_IDLE);
    end
    test_eval(16'd3, 16'd2, 16'd5, 16'd2, 16'd21);
  endtask

  task automatic test_back_to_back();
    a_in = 16'd3; b_in = 16'd2; c_in = 16'd5; x_in = 16'd2;
    start = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (ctl !== seq[i]) begin
        errors++; $display("FAIL b2b_seq[%0d]: got %b expected %b", i, ctl, seq[i]);
      end
      tick();
    end
    checks++;
    if (ctl !== E_IDLE) begin
      errors++; $display("FAIL b2b_gap_idle: got %b expected %b", ctl, E_IDLE);
    end
    tick();
    start = 1'b0;
    checks++;
    if (ctl !== E_LOADX) begin
      errors++; $display("FAIL b2b_restart: got %b expected %b", ctl, E_LOADX);
    end
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (ctl !== E_IDLE || r2 !== 16'd21) begin
      errors++; $display("FAIL b2b_drain: got ctl=%b r2=%0d expected ctl=%b r2=21", ctl, r2, E_IDLE);
    end
  endtask

  task automatic test_hold();
    start_h = 1'b1;
    tick();
    start_h = 1'b0;
    checks++;
    if (ctl_h !== E_LOADX) begin
      errors++; $display("FAIL hold_loadx: got %b expected %b", ctl_h, E_LOADX);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (ctl_h !== E_DONE) begin
      errors++; $display("FAIL hold_done: got %b expected %b", ctl_h, E_DONE);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (ctl_h !== E_DONE) begin
        errors++; $display("FAIL hold_pronto[%0d]: got %b expected %b", i, ctl_h, E_DONE);
      end
    end
    start_h = 1'b1;
    tick();
    start_h = 1'b0;
    checks++;
    if (ctl_h !== E_LOADX) begin
      errors++; $display("FAIL hold_restart: got %b expected %b", ctl_h, E_LOADX);
    end
    tick();
    checks++;
    if (ctl_h !== E_X2) begin
      errors++; $display("FAIL hold_restart_x2: got %b expected %b", ctl_h, E_X2);
    end
  endtask

  initial begin
    test_reset();
    test_eval(16'd3, 16'd2, 16'd5, 16'd2, 16'd21);
    test_eval(16'd1, 16'd0, 16'd0, 16'd300, 16'd24464);
    test_eval(16'd3, 16'd2, 16'd5, 16'd2, 16'd21);
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
